// File: rtl/fir_tap_sched.sv
// fir_tap_sched
//
// Sequencer for the symmetric-FIR pre-adder stage. For every accepted input
// sample it pulses the pre-adder enable, issues the NTAPS folded tap-sums in
// order to one shared multiplier, sums the products coming back (in issue
// order, no backpressure) and presents one filter output word.
//
// Optional feature:
//   FIR_TAP_SCHED_SAT_EN  defined   -> filter_out saturates the accumulator
//                         undefined -> filter_out is acc[OUT_W-1:0] (wrap)
//
// Ports:
//   clk, reset                 clock (rising edge), asynchronous active-high reset
//   clk_enable                 global enable; all state holds while low
//   sample_valid/sample_ready  new-sample handshake from the source
//   pipe_en                    pre-adder clk_enable, one pulse per accepted sample
//   tapsums                    packed signed tap-sums, tap k at [k*IN_W +: IN_W]
//   op_valid/op_ready          operand handshake to the shared multiplier
//   op_data, op_tap            operand and its tap index (coefficient select)
//   prod_valid, prod_data      products returned by the multiplier
//   out_valid/out_ready        output handshake, filter_out the signed result
//   err                        sticky protocol-error flag (unexpected product)

module fir_tap_sched #(
    parameter int NTAPS  = 15,
    parameter int IN_W   = 11,
    parameter int PROD_W = 22,
    parameter int ACC_W  = 26,
    parameter int OUT_W  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clk_enable,
    input  logic                    sample_valid,
    output logic                    sample_ready,
    output logic                    pipe_en,
    input  logic [NTAPS*IN_W-1:0]   tapsums,
    output logic                    op_valid,
    input  logic                    op_ready,
    output logic [IN_W-1:0]         op_data,
    output logic [3:0]              op_tap,
    input  logic                    prod_valid,
    input  logic [PROD_W-1:0]       prod_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_W-1:0]        filter_out,
    output logic                    err
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

    localparam logic [3:0] LAST_TAP = 4'(NTAPS - 1);
    localparam logic [3:0] CNT_FULL = 4'(NTAPS);

    state_t                    state_reg, state_next;
    logic [3:0]                issue_idx_reg, issue_idx_next;
    logic [3:0]                ret_cnt_reg, ret_cnt_next;
    logic signed [ACC_W-1:0]   acc_reg, acc_next;
    logic                      err_reg, err_next;

    logic                      prod_take;
    logic [3:0]                ret_cnt_inc;
    logic signed [ACC_W-1:0]   prod_ext;
    logic [OUT_W-1:0]          acc_reduced;

    // Unpack the tap-sums into a 16-entry table so the 4-bit issue index can
    // select any entry; unused entries read as zero.
    logic [IN_W-1:0] tap_arr [16];

    for (genvar gi = 0; gi < 16; gi++) begin : g_tap
        if (gi < NTAPS) begin : g_used
            assign tap_arr[gi] = tapsums[gi*IN_W +: IN_W];
        end else begin : g_unused
            assign tap_arr[gi] = '0;
        end
    end

    assign prod_ext = {{(ACC_W-PROD_W){prod_data[PROD_W-1]}}, prod_data};

`ifdef FIR_TAP_SCHED_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((64'sd1 <<< (OUT_W-1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

    always_comb begin
        acc_reduced = acc_reg[OUT_W-1:0];
        if (acc_reg > SAT_HI) begin
            acc_reduced = {1'b0, {(OUT_W-1){1'b1}}};
        end else if (acc_reg < SAT_LO) begin
            acc_reduced = {1'b1, {(OUT_W-1){1'b0}}};
        end
    end
`else
    assign acc_reduced = acc_reg[OUT_W-1:0];
`endif

    // State and datapath registers; everything freezes while clk_enable is
    // low, which also silently drops any product presented in that window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            issue_idx_reg <= '0;
            ret_cnt_reg   <= '0;
            acc_reg       <= '0;
            err_reg       <= 1'b0;
        end else if (clk_enable) begin
            state_reg     <= state_next;
            issue_idx_reg <= issue_idx_next;
            ret_cnt_reg   <= ret_cnt_next;
            acc_reg       <= acc_next;
            err_reg       <= err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        issue_idx_next = issue_idx_reg;
        ret_cnt_next   = ret_cnt_reg;
        acc_next       = acc_reg;

        sample_ready = 1'b0;
        pipe_en      = 1'b0;
        op_valid     = 1'b0;
        op_data      = '0;
        op_tap       = '0;
        out_valid    = 1'b0;
        filter_out   = '0;

        // Products are only expected while a sample is in flight and fewer
        // than NTAPS have come back; anything else is a protocol error.
        prod_take   = prod_valid && (state_reg == ISSUE || state_reg == WAIT) &&
                      (ret_cnt_reg != CNT_FULL);
        ret_cnt_inc = ret_cnt_reg + 4'(prod_take);
        err_next    = err_reg || (prod_valid && !prod_take);

        if (prod_take) begin
            acc_next     = acc_reg + prod_ext;
            ret_cnt_next = ret_cnt_inc;
        end

        unique case (state_reg)
            IDLE: begin
                sample_ready = 1'b1;
                if (sample_valid) begin
                    pipe_en        = clk_enable;
                    acc_next       = '0;
                    issue_idx_next = '0;
                    ret_cnt_next   = '0;
                    state_next     = ISSUE;
                end
            end
            ISSUE: begin
                op_valid = 1'b1;
                op_data  = tap_arr[issue_idx_reg];
                op_tap   = issue_idx_reg;
                if (op_ready) begin
                    issue_idx_next = issue_idx_reg + 4'd1;
                    if (issue_idx_reg == LAST_TAP) begin
                        state_next = (ret_cnt_inc == CNT_FULL) ? OUT : WAIT;
                    end
                end
            end
            WAIT: begin
                if (ret_cnt_inc == CNT_FULL) begin
                    state_next = OUT;
                end
            end
            OUT: begin
                out_valid  = 1'b1;
                filter_out = acc_reduced;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign err = err_reg;

endmodule

// File: tb/tb_fir_tap_sched.sv
module tb_fir_tap_sched;

    logic          clk = 1'b0;
    logic          reset;
    logic          clk_enable;
    logic          sample_valid;
    logic          sample_ready;
    logic          pipe_en;
    logic [164:0]  tapsums;
    logic          op_valid;
    logic          op_ready;
    logic [10:0]   op_data;
    logic [3:0]    op_tap;
    logic          prod_valid;
    logic [21:0]   prod_data;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   filter_out;
    logic          err;

    always #5 clk = ~clk;

    fir_tap_sched dut (
        .clk          (clk),
        .reset        (reset),
        .clk_enable   (clk_enable),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .pipe_en      (pipe_en),
        .tapsums      (tapsums),
        .op_valid     (op_valid),
        .op_ready     (op_ready),
        .op_data      (op_data),
        .op_tap       (op_tap),
        .prod_valid   (prod_valid),
        .prod_data    (prod_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .filter_out   (filter_out),
        .err          (err)
    );

    // Multiplier model: latency 2, freezes with clk_enable.
    // mode 0: product = tapsum*(tap+1); mode 1: product = tapsum*31.
    int                 mode;
    logic signed [21:0] model_prod;
    logic               m1_v, m2_v, inj_v;
    logic [21:0]        m1_d, m2_d, inj_d;

    always_comb begin
        model_prod = '0;
        if (mode == 1) model_prod = 22'(int'($signed(op_data)) * 31);
        else           model_prod = 22'(int'($signed(op_data)) * (int'(op_tap) + 1));
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m1_v <= 1'b0; m2_v <= 1'b0; m1_d <= '0; m2_d <= '0;
        end else if (clk_enable) begin
            m1_v <= op_valid && op_ready;
            m1_d <= model_prod;
            m2_v <= m1_v;
            m2_d <= m1_d;
        end
    end

    assign prod_valid = m2_v | inj_v;
    assign prod_data  = inj_v ? inj_d : m2_d;

    int pass_cnt = 0;
    int total    = 0;

    // Observations recorded by run_sample.
    int                 pe0, first_issue, last_issue, out_first, out_cycles;
    int                 hold_viol, order_err, once_cnt, timeout, tap_gap_a, tap_gap_b;
    int                 issue_cnt [16];
    logic signed [15:0] fo_val;

    task automatic set_taps(input logic [10:0] v);
        for (int k = 0; k < 15; k++) tapsums[k*11 +: 11] = v;
    endtask

    task automatic run_sample(input bit alt, input int out_hold, input int gap_start, input int gap_len);
        int n, next_tap;
        bit done, stalled;
        logic [10:0] pd;
        logic [3:0]  pt;
        first_issue = -1; last_issue = -1; out_first = -1; out_cycles = 0;
        hold_viol = 0; order_err = 0; once_cnt = 0; tap_gap_a = -1; tap_gap_b = -1;
        for (int k = 0; k < 16; k++) issue_cnt[k] = 0;
        fo_val = '0; next_tap = 0; done = 0; stalled = 0; pd = '0; pt = '0;
        @(posedge clk); #1;
        sample_valid = 1'b1; op_ready = 1'b1; clk_enable = 1'b1;
        #1 pe0 = int'(pipe_en);
        @(posedge clk); #1;
        sample_valid = 1'b0;
        n = 1;
        while (!done && n < 200) begin
            op_ready   = alt ? (n % 2 == 0) : 1'b1;
            clk_enable = !(n >= gap_start && n < gap_start + gap_len);
            #1;
            if (n == gap_start) tap_gap_a = int'(op_tap);
            if (n == gap_start + gap_len - 1) tap_gap_b = int'(op_tap);
            if (stalled && op_valid && (op_data !== pd || op_tap !== pt)) hold_viol++;
            if (op_valid) begin
                if (op_ready && clk_enable) begin
                    issue_cnt[op_tap]++;
                    if (int'(op_tap) != next_tap) order_err++;
                    next_tap++;
                    if (first_issue < 0) first_issue = n;
                    last_issue = n;
                    stalled = 0;
                end else begin
                    stalled = 1; pd = op_data; pt = op_tap;
                end
            end
            if (out_valid) begin
                if (out_first < 0) begin
                    out_first = n; fo_val = filter_out;
                end else if (filter_out !== fo_val) begin
                    hold_viol++;
                end
                out_cycles++;
                out_ready = ((n - out_first) >= out_hold);
                if (out_ready && clk_enable) done = 1;
            end
            @(posedge clk); #1;
            n++;
        end
        out_ready  = 1'b0;
        clk_enable = 1'b1;
        timeout    = done ? 0 : 1;
        for (int k = 0; k < 15; k++) if (issue_cnt[k] == 1) once_cnt++;
        $display("sample: filter_out=%0d first_issue=%0d last_issue=%0d out_cycle=%0d",
                 fo_val, first_issue, last_issue, out_first);
    endtask

    task automatic test_reset();
        total++; if (sample_ready !== 1'b1) $display("FAIL rst_sample_ready got %b want 1", sample_ready); else pass_cnt++;
        total++; if (op_valid !== 1'b0) $display("FAIL rst_op_valid got %b want 0", op_valid); else pass_cnt++;
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1 sample_valid = 1'b1;
        @(posedge clk); #1 sample_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        total++; if (op_valid !== 1'b1 || op_tap !== 4'd2) $display("FAIL mid_issue got valid=%b tap=%0d want 1/2", op_valid, op_tap); else pass_cnt++;
        #1 reset = 1'b1;
        #1;
        total++; if (op_valid !== 1'b0) $display("FAIL rst_async_op_valid got %b want 0", op_valid); else pass_cnt++;
        total++; if (op_tap !== 4'd0 || op_data !== 11'd0) $display("FAIL rst_async_op got tap=%0d data=%0d want 0/0", op_tap, op_data); else pass_cnt++;
        total++; if (out_valid !== 1'b0 || filter_out !== 16'd0) $display("FAIL rst_async_out got %b/%0d want 0/0", out_valid, filter_out); else pass_cnt++;
        total++; if (err !== 1'b0 || pipe_en !== 1'b0) $display("FAIL rst_async_err_pe got %b/%b want 0/0", err, pipe_en); else pass_cnt++;
        total++; if (sample_ready !== 1'b1) $display("FAIL rst_async_ready got %b want 1", sample_ready); else pass_cnt++;
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;
        total++; if (sample_ready !== 1'b1 || err !== 1'b0) $display("FAIL rst_release got ready=%b err=%b want 1/0", sample_ready, err); else pass_cnt++;
    endtask

    task automatic test_nominal();
        run_sample(1'b0, 0, 1000, 0);
        total++; if (pe0 != 1) $display("FAIL nom_pipe_en got %0d want 1", pe0); else pass_cnt++;
        total++; if (first_issue != 1 || last_issue != 15) $display("FAIL nom_issue_cycles got %0d..%0d want 1..15", first_issue, last_issue); else pass_cnt++;
        total++; if (order_err != 0 || once_cnt != 15) $display("FAIL nom_issue_order got err=%0d once=%0d want 0/15", order_err, once_cnt); else pass_cnt++;
        total++; if (out_first != 18 || timeout != 0) $display("FAIL nom_out_cycle got %0d (timeout=%0d) want 18", out_first, timeout); else pass_cnt++;
        total++; if (fo_val !== 16'sd120) $display("FAIL nom_filter_out got %0d want 120", fo_val); else pass_cnt++;
        #1;
        total++; if (sample_ready !== 1'b1 || err !== 1'b0) $display("FAIL nom_back_idle got ready=%b err=%b want 1/0", sample_ready, err); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        run_sample(1'b1, 3, 1000, 0);
        total++; if (first_issue != 2 || last_issue != 30) $display("FAIL bp_issue_cycles got %0d..%0d want 2..30", first_issue, last_issue); else pass_cnt++;
        total++; if (once_cnt != 15 || order_err != 0) $display("FAIL bp_issue_once got once=%0d err=%0d want 15/0", once_cnt, order_err); else pass_cnt++;
        total++; if (hold_viol != 0) $display("FAIL bp_hold got %0d violations want 0", hold_viol); else pass_cnt++;
        total++; if (out_first != 33 || out_cycles != 4) $display("FAIL bp_out got cycle=%0d len=%0d want 33/4", out_first, out_cycles); else pass_cnt++;
        total++; if (fo_val !== 16'sd120) $display("FAIL bp_filter_out got %0d want 120", fo_val); else pass_cnt++;
    endtask

    task automatic test_enable();
        run_sample(1'b0, 0, 5, 5);
        total++; if (tap_gap_a != 4 || tap_gap_b != 4) $display("FAIL en_tap_frozen got %0d/%0d want 4/4", tap_gap_a, tap_gap_b); else pass_cnt++;
        total++; if (hold_viol != 0 || once_cnt != 15) $display("FAIL en_issue got viol=%0d once=%0d want 0/15", hold_viol, once_cnt); else pass_cnt++;
        total++; if (out_first != 23) $display("FAIL en_out_delay got %0d want 23", out_first); else pass_cnt++;
        total++; if (fo_val !== 16'sd120 || err !== 1'b0) $display("FAIL en_result got %0d err=%b want 120/0", fo_val, err); else pass_cnt++;
    endtask

    task automatic test_negative();
        int exp_v;
        mode = 1;
        set_taps(11'h400);
`ifdef FIR_TAP_SCHED_SAT_EN
        exp_v = -32768;
`else
        exp_v = -17408;  // -476160 wrapped to 16 bits
`endif
        run_sample(1'b0, 0, 1000, 0);
        total++; if (int'(fo_val) != exp_v) $display("FAIL neg_filter_out got %0d want %0d", fo_val, exp_v); else pass_cnt++;
        total++; if (out_first != 18) $display("FAIL neg_out_cycle got %0d want 18", out_first); else pass_cnt++;
        mode = 0;
        set_taps(11'd1);
    endtask

    task automatic test_protocol_error();
        @(posedge clk); #1;
        inj_d = 22'd1000; inj_v = 1'b1;
        @(posedge clk); #1 inj_v = 1'b0;
        total++; if (err !== 1'b1) $display("FAIL perr_flag got %b want 1", err); else pass_cnt++;
        run_sample(1'b0, 0, 1000, 0);
        total++; if (fo_val !== 16'sd120) $display("FAIL perr_next_result got %0d want 120", fo_val); else pass_cnt++;
        total++; if (err !== 1'b1) $display("FAIL perr_sticky got %b want 1", err); else pass_cnt++;
    endtask

    initial begin
        reset = 1'b1; clk_enable = 1'b1; sample_valid = 1'b0; op_ready = 1'b1;
        out_ready = 1'b0; inj_v = 1'b0; inj_d = '0; mode = 0;
        tapsums = '0;
        set_taps(11'd1);
        @(posedge clk); @(posedge clk); #1;
        test_reset();
        test_nominal();
        test_backpressure();
        test_enable();
        test_negative();
        test_protocol_error();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule
